// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 host definitions (tx FSM encoding, command bytes, parity helper).
package ps2_pkg;
    typedef logic [2:0] tx_state_t;
    localparam tx_state_t TX_IDLE    = 3'd0;
    localparam tx_state_t TX_INHIBIT = 3'd1;
    localparam tx_state_t TX_START   = 3'd2;
    localparam tx_state_t TX_REQ     = 3'd3;
    localparam tx_state_t TX_DATA    = 3'd4;
    localparam tx_state_t TX_PARITY  = 3'd5;
    localparam tx_state_t TX_STOP    = 3'd6;
    localparam logic [7:0] CMD_RESET            = 8'hFF;
    localparam logic [7:0] CMD_ENABLE_REPORTING = 8'hF4;
    localparam logic [7:0] ACK_BYTE             = 8'hFA;
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction
endpackage

// File: rtl/ps2_tx_if.sv
// ps2_tx_if: host-side command handshake of the PS/2 transmitter.
interface ps2_tx_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_err;
    modport master (output tx_start, tx_data, input tx_ready, tx_busy, tx_done, tx_err);
    modport slave  (input tx_start, tx_data, output tx_ready, tx_busy, tx_done, tx_err);
endinterface

// File: rtl/ps2_timer.sv
// ps2_timer: loadable down-counter that stops at zero and flags it.
module ps2_timer #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         dec_i,
    input  logic [W-1:0] val_i,
    output logic         zero_o
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else if (load_i) cnt_q <= val_i;
        else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
    assign zero_o = cnt_q == '0;
endmodule

// File: rtl/ps2_tx.sv
// ps2_tx: PS/2 host-to-device byte transmitter (inhibit, request, 11-bit frame, ACK check).
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk_negedge,
    input  logic        ps2_data,
    ps2_tx_if.slave     host,
    output logic        ps2_clk_oe,
    output logic        ps2_data_oe
);
    localparam int MAXC = INHIBIT_CYCLES > TIMEOUT_CYCLES ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW = $clog2(MAXC + 1);
    // Load values chosen so the zero flag is seen exactly INHIBIT_CYCLES cycles after tx_start,
    // and tx_err becomes visible exactly TIMEOUT_CYCLES cycles after the last negedge.
    localparam logic [TW-1:0] INH_LOAD = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LOAD  = TW'(TIMEOUT_CYCLES - 2);
    tx_state_t   state_q, state_d;
    logic [7:0]  data_q, data_d;
    logic        par_q, par_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        clk_oe_q, clk_oe_d, data_oe_q, data_oe_d;
    logic        done_q, done_d, err_q, err_d, ready_q, busy_q;
    logic        tmr_load, tmr_dec, tmr_zero;
    logic [TW-1:0] tmr_val;
    ps2_timer #(.W(TW)) u_timer (
        .clk(clk), .rst(rst), .load_i(tmr_load), .dec_i(tmr_dec), .val_i(tmr_val), .zero_o(tmr_zero)
    );
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_d     = par_q;
        cnt_d     = cnt_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        tmr_load  = 1'b0;
        tmr_dec   = 1'b0;
        tmr_val   = TO_LOAD;
        case (state_q)
            TX_IDLE: if (host.tx_start) begin
                state_d   = TX_INHIBIT;
                data_d    = host.tx_data;
                par_d     = odd_parity(host.tx_data);
                cnt_d     = 4'd0;
                clk_oe_d  = 1'b1;
                data_oe_d = 1'b0;
                tmr_load  = 1'b1;
                tmr_val   = INH_LOAD;
            end
            TX_INHIBIT: if (tmr_zero) begin
                state_d   = TX_START;
                data_oe_d = 1'b1;
            end else tmr_dec = 1'b1;
            TX_START: begin
                state_d  = TX_REQ;
                clk_oe_d = 1'b0;
                tmr_load = 1'b1;
            end
            default: if (ps2_clk_negedge) begin
                tmr_load = 1'b1;
                case (state_q)
                    TX_REQ: begin
                        data_oe_d = ~data_q[0];
                        cnt_d     = 4'd1;
                        state_d   = TX_DATA;
                    end
                    TX_DATA: if (cnt_q == 4'd8) begin
                        data_oe_d = ~par_q;
                        state_d   = TX_PARITY;
                    end else begin
                        data_oe_d = ~data_q[cnt_q[2:0]];
                        cnt_d     = cnt_q + 4'd1;
                    end
                    TX_PARITY: begin
                        data_oe_d = 1'b0;
                        state_d   = TX_STOP;
                    end
                    default: begin
                        state_d = TX_IDLE;
                        done_d  = ~ps2_data;
                        err_d   = ps2_data;
                    end
                endcase
            end else if (tmr_zero) begin
                state_d   = TX_IDLE;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                err_d     = 1'b1;
            end else tmr_dec = 1'b1;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= TX_IDLE;
            data_q    <= '0;
            par_q     <= 1'b0;
            cnt_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_q     <= par_d;
            cnt_q     <= cnt_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ready_q   <= state_d == TX_IDLE;
            busy_q    <= state_d != TX_IDLE;
        end
    end
    assign ps2_clk_oe    = clk_oe_q;
    assign ps2_data_oe   = data_oe_q;
    assign host.tx_ready = ready_q;
    assign host.tx_busy  = busy_q;
    assign host.tx_done  = done_q;
    assign host.tx_err   = err_q;
endmodule
